// File: rtl/ad9914_pkg.sv
// Shared state encoding, profile record layout and power-on tuning words
// for the AD9914 sweep scheduler.
package ad9914_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD       = 4'd1,
    ST_LOAD_ACK   = 4'd2,
    ST_CFG        = 4'd3,
    ST_CFG_ACK    = 4'd4,
    ST_SWP        = 4'd5,
    ST_SWP_ACK    = 4'd6,
    ST_DOVER_WAIT = 4'd7,
    ST_DWELL      = 4'd8,
    ST_NEXT       = 4'd9
  } state_t;

  localparam logic [31:0] DEF_LOWER = 32'd1105322465;
  localparam logic [31:0] DEF_UPPER = 32'd1421128884;
  localparam logic [31:0] DEF_STEP  = 32'd12632;
  localparam logic [15:0] DEF_RATE  = 16'h0001;
  localparam logic        DEF_EDGE  = 1'b1;

  localparam int PROF_W = 113;

  typedef struct packed {
    logic [31:0] lower;
    logic [31:0] upper;
    logic [31:0] step;
    logic [15:0] rate;
    logic        pos_edge;
  } prof_t;

  function automatic prof_t prof_default();
    prof_t p;
    p.lower    = DEF_LOWER;
    p.upper    = DEF_UPPER;
    p.step     = DEF_STEP;
    p.rate     = DEF_RATE;
    p.pos_edge = DEF_EDGE;
    return p;
  endfunction

endpackage

// File: rtl/ad9914_prof_table.sv
// Sweep profile storage: one synchronous write port, one combinational read port.
module ad9914_prof_table
  import ad9914_pkg::*;
#(
  parameter int NPROF = 4,
  parameter int IW    = $clog2(NPROF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  prof_t         wdata,
  input  logic [IW-1:0] raddr,
  output prof_t         rdata
);

  logic [PROF_W-1:0] prof_mem_r [NPROF];

  // Table write, reset to the power-on tuning words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPROF; i++) begin
        prof_mem_r[i] <= prof_default();
      end
    end else if (we) begin
      prof_mem_r[waddr] <= wdata;
    end
  end

  assign rdata = prof_t'(prof_mem_r[raddr]);

endmodule

// File: rtl/ad9914_sweep_sched.sv
// Sequences stored sweep profiles into the AD9914 controller: load limits,
// configure steps, start the sweep, wait for dover, dwell, then advance.
module ad9914_sweep_sched
  import ad9914_pkg::*;
#(
  parameter int          NPROF         = 4,
  parameter logic [31:0] DOVER_TIMEOUT = 32'd1_000_000,
  parameter int          IW            = $clog2(NPROF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [31:0]   cfg_lower,
  input  logic [31:0]   cfg_upper,
  input  logic [31:0]   cfg_step,
  input  logic [15:0]   cfg_rate,
  input  logic          cfg_edge,
  input  logic [IW:0]   num_prof,
  input  logic          loop_en,
  input  logic [15:0]   dwell,
  input  logic          start,
  input  logic          stop,
  output logic          ctl_update,
  output logic          ctl_update_config,
  output logic          ctl_sweep,
  output logic          ctl_sweep_edge,
  output logic [31:0]   ctl_lower_limit,
  output logic [31:0]   ctl_upper_limit,
  output logic [31:0]   ctl_pos_step,
  output logic [31:0]   ctl_neg_step,
  output logic [15:0]   ctl_pos_rate,
  output logic [15:0]   ctl_neg_rate,
  input  logic          ctl_busy,
  input  logic          ctl_finish,
  input  logic          dover,
  output logic          busy,
  output logic          done,
  output logic          err_timeout,
  output logic [IW-1:0] cur_idx
);

  localparam logic [IW:0]   NPROF_W = (IW+1)'(NPROF);
  localparam logic [IW:0]   ONE_W   = (IW+1)'(1'b1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1'b1);

  state_t        state_r;
  logic [IW-1:0] cur_idx_r;
  logic          ack_seen_r;
  logic          stop_pend_r;
  logic          dover_q_r;
  logic [31:0]   tmo_cnt_r;
  logic [15:0]   dwell_cnt_r;

  prof_t       slot_s;
  prof_t       cfg_data_s;
  logic [IW:0] num_eff_s;
  logic [IW:0] last_idx_s;
  logic        table_we_s;
  logic        cmd_ready_s;
  logic        stop_any_s;
  logic        dover_rise_s;

  assign cfg_data_s   = '{lower: cfg_lower, upper: cfg_upper, step: cfg_step,
                          rate: cfg_rate, pos_edge: cfg_edge};
  assign table_we_s   = cfg_we && (state_r == ST_IDLE);
  assign cmd_ready_s  = ctl_finish && !ctl_busy;
  assign stop_any_s   = stop || stop_pend_r;
  assign dover_rise_s = dover && !dover_q_r;
  assign cur_idx      = cur_idx_r;

  ad9914_prof_table #(.NPROF(NPROF), .IW(IW)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (table_we_s),
    .waddr (cfg_idx),
    .wdata (cfg_data_s),
    .raddr (cur_idx_r),
    .rdata (slot_s)
  );

  // Active profile count: zero behaves as one, oversize saturates to NPROF.
  always_comb begin
    num_eff_s = num_prof;
    if (num_prof == {(IW+1){1'b0}}) begin
      num_eff_s = ONE_W;
    end else if (num_prof > NPROF_W) begin
      num_eff_s = NPROF_W;
    end else begin
      num_eff_s = num_prof;
    end
    last_idx_s = num_eff_s - ONE_W;
  end

  // Scheduler FSM with registered command pulses, data and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      cur_idx_r         <= '0;
      ack_seen_r        <= 1'b0;
      stop_pend_r       <= 1'b0;
      dover_q_r         <= 1'b0;
      tmo_cnt_r         <= 32'd0;
      dwell_cnt_r       <= 16'd0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err_timeout       <= 1'b0;
      ctl_update        <= 1'b0;
      ctl_update_config <= 1'b0;
      ctl_sweep         <= 1'b0;
      ctl_sweep_edge    <= 1'b0;
      ctl_lower_limit   <= 32'd0;
      ctl_upper_limit   <= 32'd0;
      ctl_pos_step      <= 32'd0;
      ctl_neg_step      <= 32'd0;
      ctl_pos_rate      <= 16'd0;
      ctl_neg_rate      <= 16'd0;
    end else begin
      ctl_update        <= 1'b0;
      ctl_update_config <= 1'b0;
      ctl_sweep         <= 1'b0;
      done              <= 1'b0;
      dover_q_r         <= dover;
      // A stop seen mid-run is remembered until the next abort boundary.
      if (stop && (state_r != ST_IDLE)) stop_pend_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          stop_pend_r <= 1'b0;
          if (start && !stop) begin
            err_timeout <= 1'b0;
            cur_idx_r   <= '0;
            busy        <= 1'b1;
            state_r     <= ST_LOAD;
          end
        end
        ST_LOAD, ST_CFG, ST_SWP: begin
          if (stop_any_s) begin
            busy        <= 1'b0;
            stop_pend_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (cmd_ready_s) begin
            ack_seen_r <= 1'b0;
            case (state_r)
              ST_LOAD: begin
                ctl_update      <= 1'b1;
                ctl_lower_limit <= slot_s.lower;
                ctl_upper_limit <= slot_s.upper;
                ctl_pos_rate    <= slot_s.rate;
                ctl_neg_rate    <= slot_s.rate;
                state_r         <= ST_LOAD_ACK;
              end
              ST_CFG: begin
                ctl_update_config <= 1'b1;
                ctl_pos_step      <= slot_s.step;
                ctl_neg_step      <= slot_s.step;
                ctl_sweep_edge    <= slot_s.pos_edge;
                state_r           <= ST_CFG_ACK;
              end
              default: begin
                ctl_sweep <= 1'b1;
                state_r   <= ST_SWP_ACK;
              end
            endcase
          end
        end
        ST_LOAD_ACK, ST_CFG_ACK, ST_SWP_ACK: begin
          if (!ack_seen_r) begin
            ack_seen_r <= ctl_busy;
          end else if (ctl_finish) begin
            ack_seen_r <= 1'b0;
            case (state_r)
              ST_LOAD_ACK: state_r <= ST_CFG;
              ST_CFG_ACK:  state_r <= ST_SWP;
              default: begin
                tmo_cnt_r <= DOVER_TIMEOUT;
                state_r   <= ST_DOVER_WAIT;
              end
            endcase
          end
        end
        ST_DOVER_WAIT: begin
          if (dover_rise_s || (tmo_cnt_r <= 32'd1)) begin
            if (!dover_rise_s) err_timeout <= 1'b1;
            tmo_cnt_r <= 32'd0;
            if (dwell == 16'd0) begin
              state_r <= ST_NEXT;
            end else begin
              dwell_cnt_r <= dwell;
              state_r     <= ST_DWELL;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r - 32'd1;
          end
        end
        ST_DWELL: begin
          if (stop_any_s) begin
            busy        <= 1'b0;
            stop_pend_r <= 1'b0;
            dwell_cnt_r <= 16'd0;
            state_r     <= ST_IDLE;
          end else if (dwell_cnt_r <= 16'd1) begin
            dwell_cnt_r <= 16'd0;
            state_r     <= ST_NEXT;
          end else begin
            dwell_cnt_r <= dwell_cnt_r - 16'd1;
          end
        end
        ST_NEXT: begin
          if (stop_any_s) begin
            busy        <= 1'b0;
            stop_pend_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else if ({1'b0, cur_idx_r} < last_idx_s) begin
            cur_idx_r <= cur_idx_r + IDX_ONE;
            state_r   <= ST_LOAD;
          end else if (loop_en) begin
            cur_idx_r <= '0;
            state_r   <= ST_LOAD;
          end else begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9914_sweep_sched.sv
// Directed bench: two scheduler instances (default and 50-cycle dover timeout),
// each driven by a simple DDS controller model that acks 5 cycles after a pulse.
module tb_ad9914_sweep_sched;

  localparam int W_UPD_A = 0, W_UCF_A = 1, W_SWP_A = 2, W_DONE_A = 3, W_IDLE_A = 4;
  localparam int W_UPD_B = 5, W_SWP_B = 6, W_CBSY_B = 7, W_CFIN_B = 8, W_DONE_B = 9, W_IDLE_B = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cfg_we, cfg_edge, loop_en, stop;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_lower, cfg_upper, cfg_step;
  logic [15:0] cfg_rate, dwell;
  logic [2:0]  num_prof;
  logic        start_a, start_b, dover_a, dover_b, hold_a;

  logic        upd_a, ucf_a, swp_a, edge_a, busy_a, done_a, err_a;
  logic [31:0] lo_a, up_a, ps_a, ns_a;
  logic [15:0] pr_a, nr_a;
  logic [1:0]  idx_a;
  logic        upd_b, ucf_b, swp_b, edge_b, busy_b, done_b, err_b;
  logic [31:0] lo_b, up_b, ps_b, ns_b;
  logic [15:0] pr_b, nr_b;
  logic [1:0]  idx_b;

  logic cbusy_a = 1'b0, cfin_r_a = 1'b1, cbusy_b = 1'b0, cfin_b = 1'b1;
  logic cfin_a;
  int   ccnt_a = 0, ccnt_b = 0;
  int   n_upd_a = 0, n_done_a = 0;
  int   tests = 0, fails = 0;

  assign cfin_a = cfin_r_a & ~hold_a;

  ad9914_sweep_sched #(.NPROF(4)) dut_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lower(cfg_lower),
    .cfg_upper(cfg_upper), .cfg_step(cfg_step), .cfg_rate(cfg_rate), .cfg_edge(cfg_edge),
    .num_prof(num_prof), .loop_en(loop_en), .dwell(dwell), .start(start_a), .stop(stop),
    .ctl_update(upd_a), .ctl_update_config(ucf_a), .ctl_sweep(swp_a), .ctl_sweep_edge(edge_a),
    .ctl_lower_limit(lo_a), .ctl_upper_limit(up_a), .ctl_pos_step(ps_a), .ctl_neg_step(ns_a),
    .ctl_pos_rate(pr_a), .ctl_neg_rate(nr_a), .ctl_busy(cbusy_a), .ctl_finish(cfin_a),
    .dover(dover_a), .busy(busy_a), .done(done_a), .err_timeout(err_a), .cur_idx(idx_a)
  );

  ad9914_sweep_sched #(.NPROF(4), .DOVER_TIMEOUT(32'd50)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lower(cfg_lower),
    .cfg_upper(cfg_upper), .cfg_step(cfg_step), .cfg_rate(cfg_rate), .cfg_edge(cfg_edge),
    .num_prof(num_prof), .loop_en(loop_en), .dwell(dwell), .start(start_b), .stop(stop),
    .ctl_update(upd_b), .ctl_update_config(ucf_b), .ctl_sweep(swp_b), .ctl_sweep_edge(edge_b),
    .ctl_lower_limit(lo_b), .ctl_upper_limit(up_b), .ctl_pos_step(ps_b), .ctl_neg_step(ns_b),
    .ctl_pos_rate(pr_b), .ctl_neg_rate(nr_b), .ctl_busy(cbusy_b), .ctl_finish(cfin_b),
    .dover(dover_b), .busy(busy_b), .done(done_b), .err_timeout(err_b), .cur_idx(idx_b)
  );

  // Controller models: busy for 5 cycles after any command pulse.
  always @(negedge clk) begin
    if (upd_a | ucf_a | swp_a) begin
      cbusy_a <= 1'b1; cfin_r_a <= 1'b0; ccnt_a <= 5;
    end else if (ccnt_a > 0) begin
      ccnt_a <= ccnt_a - 1;
      if (ccnt_a == 1) begin cbusy_a <= 1'b0; cfin_r_a <= 1'b1; end
    end
    if (upd_b | ucf_b | swp_b) begin
      cbusy_b <= 1'b1; cfin_b <= 1'b0; ccnt_b <= 5;
    end else if (ccnt_b > 0) begin
      ccnt_b <= ccnt_b - 1;
      if (ccnt_b == 1) begin cbusy_b <= 1'b0; cfin_b <= 1'b1; end
    end
    if (upd_a)  n_upd_a  <= n_upd_a + 1;
    if (done_a) n_done_a <= n_done_a + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      W_UPD_A:  return upd_a;
      W_UCF_A:  return ucf_a;
      W_SWP_A:  return swp_a;
      W_DONE_A: return done_a;
      W_IDLE_A: return ~busy_a;
      W_UPD_B:  return upd_b;
      W_SWP_B:  return swp_b;
      W_CBSY_B: return cbusy_b;
      W_CFIN_B: return cfin_b;
      W_DONE_B: return done_b;
      W_IDLE_B: return ~busy_b;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input string tag);
    int n = 0;
    while (sig(w) !== 1'b1 && n < 3000) begin tick(1); n++; end
    chk({"wait ", tag}, {31'd0, sig(w)}, 32'd1);
  endtask

  task automatic cfg_write(input logic [1:0] i, input logic [31:0] lo, up, st,
                           input logic [15:0] rt, input logic ed);
    cfg_idx = i; cfg_lower = lo; cfg_upper = up; cfg_step = st; cfg_rate = rt; cfg_edge = ed;
    cfg_we = 1'b1; tick(1); cfg_we = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  logic [31:0] exp_lo [4], exp_up [4], exp_st [4];
  logic [15:0] exp_rt [4];
  logic        exp_ed [4];
  logic [1:0]  seq [5];
  int ubase, dbase;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_lower = 32'd0; cfg_upper = 32'd0;
    cfg_step = 32'd0; cfg_rate = 16'd0; cfg_edge = 1'b0; num_prof = 3'd1; loop_en = 1'b0;
    dwell = 16'd0; stop = 1'b0; start_a = 1'b0; start_b = 1'b0; dover_a = 1'b0;
    dover_b = 1'b0; hold_a = 1'b0;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0; seq[4] = 2'd1;
    tick(3);
    chk("reset busy", busy_a, 32'd0);
    chk("reset pulses", {upd_a, ucf_a, swp_a, done_a, err_a}, 32'd0);
    chk("reset cur_idx", idx_a, 32'd0);
    rst = 1'b0; tick(2);

    // start and stop together in IDLE: stop wins
    start_a = 1'b1; stop = 1'b1; tick(1); start_a = 1'b0; stop = 1'b0;
    chk("start+stop busy", busy_a, 32'd0);
    tick(3);
    chk("start+stop no update", n_upd_a, 32'd0);

    // single profile
    cfg_write(2'd0, 32'h1111_0000, 32'h2222_0000, 32'h0000_0333, 16'h0044, 1'b0);
    num_prof = 3'd1; loop_en = 1'b0; dwell = 16'd10;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    chk("s1 busy", busy_a, 32'd1);
    wait_for(W_UPD_A, "s1 update");
    chk("s1 order", {ucf_a, swp_a}, 32'd0);
    chk("s1 lower", lo_a, 32'h1111_0000);
    chk("s1 upper", up_a, 32'h2222_0000);
    chk("s1 rates", {pr_a, nr_a}, 32'h0044_0044);
    wait_for(W_UCF_A, "s1 update_config");
    chk("s1 steps", ps_a ^ ns_a, 32'd0);
    chk("s1 pos_step", ps_a, 32'h0000_0333);
    chk("s1 edge", edge_a, 32'd0);
    chk("s1 lower held", lo_a, 32'h1111_0000);
    wait_for(W_SWP_A, "s1 sweep");
    tick(100);
    dover_a = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 2) dover_a = 1'b0;
      if (k == 11) chk("s1 done early", done_a, 32'd0);
      if (k == 12) begin
        chk("s1 done at dwell+1", done_a, 32'd1);
        chk("s1 busy cleared", busy_a, 32'd0);
      end
    end

    // loop wrap over three of four slots
    for (int i = 0; i < 4; i++) begin
      exp_lo[i] = 32'h1000_0000 + i; exp_up[i] = 32'h2000_0000 + i;
      exp_st[i] = 32'h0000_0300 + i; exp_rt[i] = 16'h0040 + 16'(i); exp_ed[i] = (i % 2 == 1);
      cfg_write(2'(i), exp_lo[i], exp_up[i], exp_st[i], exp_rt[i], exp_ed[i]);
    end
    num_prof = 3'd3; loop_en = 1'b1; dwell = 16'd2;
    ubase = n_upd_a; dbase = n_done_a;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    for (int p = 0; p < 5; p++) begin
      wait_for(W_UPD_A, "s2 update");
      chk("s2 cur_idx", idx_a, seq[p]);
      chk("s2 lower", lo_a, exp_lo[seq[p]]);
      chk("s2 upper", up_a, exp_up[seq[p]]);
      chk("s2 rate", pr_a, exp_rt[seq[p]]);
      wait_for(W_UCF_A, "s2 update_config");
      chk("s2 step", ns_a, exp_st[seq[p]]);
      chk("s2 edge", edge_a, exp_ed[seq[p]]);
      wait_for(W_SWP_A, "s2 sweep");
      if (p == 4) pulse_stop();
      tick(10); dover_a = 1'b1; tick(2); dover_a = 1'b0;
    end
    wait_for(W_IDLE_A, "s2 stopped");
    chk("s2 update count", n_upd_a - ubase, 32'd5);
    chk("s2 no done", n_done_a - dbase, 32'd0);

    // dover timeout on the 50-cycle instance
    num_prof = 3'd2; loop_en = 1'b0; dwell = 16'd0;
    start_b = 1'b1; tick(1); start_b = 1'b0;
    wait_for(W_SWP_B, "s3 sweep");
    wait_for(W_CBSY_B, "s3 ctl busy");
    wait_for(W_CFIN_B, "s3 ctl finish");
    for (int k = 1; k <= 50; k++) begin
      tick(1);
      if (k == 49) chk("s3 err early", err_b, 32'd0);
      if (k == 50) chk("s3 err at 50", err_b, 32'd1);
    end
    wait_for(W_UPD_B, "s3 next update");
    chk("s3 cur_idx", idx_b, 32'd1);
    chk("s3 lower", lo_b, exp_lo[1]);
    wait_for(W_DONE_B, "s3 done");
    chk("s3 err sticky", err_b, 32'd1);
    chk("s3 busy", busy_b, 32'd0);
    start_b = 1'b1; tick(1); start_b = 1'b0;
    chk("s3 err cleared", err_b, 32'd0);
    pulse_stop();
    wait_for(W_IDLE_B, "s3 idle");

    // stop during dwell
    num_prof = 3'd1; loop_en = 1'b1; dwell = 16'd20;
    ubase = n_upd_a; dbase = n_done_a;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_for(W_SWP_A, "s4 sweep");
    tick(10);
    dover_a = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (k == 2) dover_a = 1'b0;
    end
    chk("s4 busy in dwell", busy_a, 32'd1);
    pulse_stop();
    chk("s4 busy cleared", busy_a, 32'd0);
    tick(40);
    chk("s4 no new update", n_upd_a - ubase, 32'd1);
    chk("s4 no done", n_done_a - dbase, 32'd0);

    // controller not ready
    hold_a = 1'b1; num_prof = 3'd1; loop_en = 1'b0; dwell = 16'd0;
    ubase = n_upd_a;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    tick(30);
    chk("s5 no pulse while not ready", n_upd_a - ubase, 32'd0);
    chk("s5 busy", busy_a, 32'd1);
    hold_a = 1'b0;
    tick(5);
    chk("s5 one pulse", n_upd_a - ubase, 32'd1);
    pulse_stop();
    wait_for(W_IDLE_A, "s5 idle");

    // reset during dover wait
    cfg_write(2'd0, 32'hAAAA_5555, 32'hBBBB_6666, 32'h0000_7777, 16'h0088, 1'b0);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_for(W_SWP_A, "s6 sweep");
    tick(10);
    rst = 1'b1; #1;
    chk("s6 status", {busy_a, done_a, err_a, idx_a, busy_b, done_b, err_b, idx_b}, 32'd0);
    chk("s6 pulses", {upd_a, ucf_a, swp_a, edge_a, upd_b, ucf_b, swp_b, edge_b}, 32'd0);
    chk("s6 data a", lo_a | up_a | ps_a | ns_a | {pr_a, nr_a}, 32'd0);
    chk("s6 data b", lo_b | up_b | ps_b | ns_b | {pr_b, nr_b}, 32'd0);
    tick(2); rst = 1'b0; tick(2);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_for(W_UPD_A, "s6 default update");
    chk("s6 default lower", lo_a, 32'd1105322465);
    chk("s6 default upper", up_a, 32'd1421128884);
    chk("s6 default rate", {pr_a, nr_a}, 32'h0001_0001);
    wait_for(W_UCF_A, "s6 default update_config");
    chk("s6 default step", ps_a, 32'd12632);
    chk("s6 default edge", edge_a, 32'd1);
    pulse_stop();
    wait_for(W_IDLE_A, "s6 idle");
    cfg_write(2'd0, 32'hAAAA_5555, 32'hBBBB_6666, 32'h0000_7777, 16'h0088, 1'b0);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_for(W_UPD_A, "s6 written update");
    chk("s6 written lower", lo_a, 32'hAAAA_5555);
    pulse_stop();
    wait_for(W_IDLE_A, "s6 final idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ad9914_sweep_sched.md
AD9914_SWEEP_SCHED -- requirements
Module: ad9914_sweep_sched

Interface
REQ-001 Parameter NPROF, default 4, gives the number of sweep profile slots (power of 2, 2..8).
REQ-002 Parameter DOVER_TIMEOUT, default 32'd1_000_000, gives the clk cycles allowed between sweep acceptance and dover.
REQ-003 Ports are listed as name, direction, width, meaning:
  clk  in  1  single clock for all logic.
  rst  in  1  asynchronous reset, active-high.
  cfg_we  in  1  writes the profile slot selected by cfg_idx.
  cfg_idx  in  log2(NPROF)  profile slot index.
  cfg_lower, cfg_upper, cfg_step  in  32 each  frequency tuning words.
  cfg_rate  in  16  ramp rate.
  cfg_edge  in  1  sweep direction: 1 = positive, 0 = negative.
  num_prof  in  log2(NPROF)+1  active profile count; 0 is treated as 1.
  loop_en  in  1  wrap back to slot 0 after the last active slot.
  dwell  in  16  idle cycles held between profiles.
  start  in  1  one-cycle request to begin a run.
  stop  in  1  one-cycle abort request.
  ctl_update, ctl_update_config, ctl_sweep  out  1  one-cycle command pulses to the DDS controller.
  ctl_sweep_edge  out  1  direction for the command.
  ctl_lower_limit, ctl_upper_limit, ctl_pos_step, ctl_neg_step  out  32  command data.
  ctl_pos_rate, ctl_neg_rate  out  16  command data.
  ctl_busy, ctl_finish  in  1  controller status.
  dover  in  1  DDS digital-ramp-over flag.
  busy  out  1  a run is in progress.
  done  out  1  one-cycle pulse when a run ends normally.
  err_timeout  out  1  sticky; cleared by start.
  cur_idx  out  log2(NPROF)  slot currently being executed.

Function
REQ-004 The profile table SHALL be NPROF registers; cfg_we SHALL write a slot whenever the FSM is in IDLE and SHALL be ignored otherwise.
REQ-005 The FSM states SHALL be IDLE, LOAD, LOAD_ACK, CFG, CFG_ACK, SWP, SWP_ACK, DOVER_WAIT, DWELL, NEXT.
REQ-006 In IDLE, start SHALL clear err_timeout, set cur_idx=0, set busy=1, and move to LOAD.
REQ-007 A command state (LOAD, CFG, SWP) SHALL pulse its command for exactly one cycle only when ctl_finish=1 and ctl_busy=0, then move to its matching _ACK state.
REQ-008 An _ACK state SHALL wait until ctl_busy=1 and then until ctl_finish=1 before advancing.
REQ-009 Command data SHALL be driven from the slot and held stable from the pulse cycle until the _ACK state exits.
REQ-010 The LOAD command SHALL drive lower and upper from the slot, with ctl_pos_rate = ctl_neg_rate = the slot rate.
REQ-011 The CFG command SHALL drive ctl_pos_step = ctl_neg_step = the slot step and ctl_sweep_edge = the slot edge.
REQ-012 After SWP_ACK the FSM SHALL enter DOVER_WAIT and load a 32-bit timeout counter.
REQ-013 In DOVER_WAIT, a rising edge of dover (registered one stage) SHALL go to DWELL; counter expiry SHALL set err_timeout and go to DWELL.
REQ-014 DWELL SHALL count exactly dwell cycles (0 means no cycles) and then go to NEXT.
REQ-015 In NEXT, if cur_idx < num_prof-1 the FSM SHALL increment cur_idx and go to LOAD.
REQ-016 In NEXT, if cur_idx is the last slot and loop_en=1, cur_idx SHALL wrap to 0 and the FSM SHALL go to LOAD.
REQ-017 In NEXT, if cur_idx is the last slot and loop_en=0, the FSM SHALL pulse done, clear busy, and return to IDLE.
REQ-018 stop in any non-IDLE state SHALL take effect at the next command-state or DWELL boundary: no new command is issued, busy clears, done is not pulsed, and the FSM returns to IDLE. A pending _ACK SHALL complete first.
REQ-019 When start and stop are asserted in the same cycle in IDLE, stop SHALL win and the FSM SHALL stay in IDLE.
REQ-020 start while busy SHALL be ignored.
REQ-021 If num_prof > NPROF, the block SHALL saturate it to NPROF.

Reset
REQ-022 Reset SHALL return the FSM to IDLE and clear busy, done, err_timeout, cur_idx, all ctl_* pulses and all counters to 0.
REQ-023 Reset SHALL set the profile table to lower=1105322465, upper=1421128884, step=12632, rate=16'h0001, edge=1.
REQ-024 Reset asserted mid-sweep SHALL take effect immediately, with no command pulse issued on the reset cycle.

Structure
REQ-025 The state enum, default tuning words and the profile record width SHALL live in shared package ad9914_pkg.
REQ-026 The profile table SHALL be a separate sub-module, ad9914_prof_table, with one write port and one combinational read port.

Verification
REQ-027 Bench scenario, single profile: num_prof=1, loop_en=0, controller model acks after 5 cycles, dover after 100 cycles -> pulses in order update, update_config, sweep, then done after dwell+1 cycles.
REQ-028 Bench scenario, loop wrap: NPROF=4, num_prof=3, loop_en=1 -> cur_idx sequence 0,1,2,0,1; each command's data matches its slot.
REQ-029 Bench scenario, timeout: dover is never asserted, DOVER_TIMEOUT=50 -> err_timeout=1 exactly 50 cycles after SWP_ACK exits, and the run continues to the next profile.
REQ-030 Bench scenario, stop in DWELL: dwell=20, stop raised at dwell cycle 5 -> busy=0 within 1 cycle, no further ctl_update, no done.
REQ-031 Bench scenario, controller not ready: ctl_finish held low for 30 cycles -> no command pulse until ctl_finish=1, then exactly one pulse.
REQ-032 Bench scenario, reset in DOVER_WAIT: rst asserted -> all outputs 0 the same cycle, the table holds default values, and cfg_we writes are accepted after release.
